// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter that shares one CacheCore between NUM_PORTS requesters,
// with one transaction in flight and an optional per-port lock that has an idle timeout.
module cache_port_arbiter #(
  parameter  int NUM_PORTS    = 4,
  parameter  int ADDR_W       = 24,
  parameter  int DATA_W       = 512,
  parameter  int LOCK_TIMEOUT = 255,
  localparam int MASK_W       = DATA_W / 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  input  logic [NUM_PORTS*MASK_W-1:0] req_mask,
  input  logic [NUM_PORTS-1:0]        req_lock,
  output logic                        core_req_valid,
  input  logic                        core_req_ready,
  output logic [ADDR_W-1:0]           core_req_addr,
  output logic [DATA_W-1:0]           core_req_data,
  output logic [MASK_W-1:0]           core_req_mask,
  output logic                        core_req_lock,
  output logic [3:0]                  core_req_port,
  input  logic                        core_resp_valid,
  output logic                        core_resp_ready,
  input  logic [DATA_W-1:0]           core_resp_data,
  input  logic                        core_resp_success,
  output logic [NUM_PORTS-1:0]        resp_valid,
  input  logic [NUM_PORTS-1:0]        resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_success,
  output logic                        busy,
  output logic                        locked,
  output logic [3:0]                  lock_owner,
  output logic                        lock_timeout
);

  localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam logic [NUM_PORTS-1:0] PORT_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      last_grant;
  logic [3:0]      win_idx;
  logic            win_valid;
  logic [4:0]      cand;
  logic [15:0]     valid_ext, elig_ext, resp_ready_ext;
  logic [CW-1:0]   lock_cnt;
  logic            accept, issue_done, resp_done, owner_idle, timeout_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [MASK_W-1:0] sel_mask;
  logic              sel_lock;

  // Vectors padded to 16 bits so a 4-bit port index selects them exactly.
  assign valid_ext      = 16'(req_valid);
  assign resp_ready_ext = 16'(resp_ready);
  assign elig_ext       = locked ? (valid_ext & (16'b1 << lock_owner)) : valid_ext;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_grant} + 5'(k);
      if (cand >= 5'(NUM_PORTS)) cand = cand - 5'(NUM_PORTS);
      if (!win_valid && elig_ext[cand[3:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == 4'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_mask = req_mask[i*MASK_W +: MASK_W];
        sel_lock = req_lock[i];
      end
    end
  end

  assign accept      = (state == IDLE) && win_valid;
  assign issue_done  = (state == ISSUE) && core_req_ready;
  assign resp_done   = (state == WAIT_RESP) && core_resp_valid && resp_ready_ext[core_req_port];
  assign owner_idle  = (state == IDLE) && locked && !valid_ext[lock_owner];
  assign timeout_hit = owner_idle && (lock_cnt == CW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept)     state_next = ISSUE;
      ISSUE:     if (issue_done) state_next = WAIT_RESP;
      WAIT_RESP: if (resp_done)  state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    core_req_valid  = 1'b0;
    core_resp_ready = 1'b0;
    resp_valid      = '0;
    busy            = 1'b0;
    case (state)
      IDLE:      if (win_valid && reset) req_ready = PORT_ONE << win_idx;
      ISSUE: begin
        core_req_valid = 1'b1;
        busy           = 1'b1;
      end
      WAIT_RESP: begin
        busy            = 1'b1;
        core_resp_ready = resp_ready_ext[core_req_port];
        if (core_resp_valid) resp_valid = PORT_ONE << core_req_port;
      end
      default: ;
    endcase
  end

  assign resp_data    = core_resp_data;
  assign resp_success = core_resp_success;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant    <= 4'(NUM_PORTS - 1);
      core_req_port <= '0;
      core_req_addr <= '0;
      core_req_data <= '0;
      core_req_mask <= '0;
      core_req_lock <= 1'b0;
    end else if (accept) begin
      last_grant    <= win_idx;
      core_req_port <= win_idx;
      core_req_addr <= sel_addr;
      core_req_data <= sel_data;
      core_req_mask <= sel_mask;
      core_req_lock <= sel_lock;
    end
  end

  // Lock ownership follows completed responses; an idle owner loses it after the timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      locked       <= 1'b0;
      lock_owner   <= '0;
      lock_timeout <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      lock_timeout <= 1'b0;
      if (resp_done) begin
        if (core_req_lock && core_resp_success) begin
          locked     <= 1'b1;
          lock_owner <= core_req_port;
        end else if (!core_req_lock && core_req_port == lock_owner) begin
          locked <= 1'b0;
        end
      end
      if (timeout_hit) begin
        locked       <= 1'b0;
        lock_timeout <= 1'b1;
        lock_cnt     <= '0;
      end else if (owner_idle) begin
        lock_cnt <= lock_cnt + CW'(1);
      end else begin
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomised bench for cache_port_arbiter: a transaction-level model predicts grants,
// lock state and responses; a monitor process checks the core-side and response handshakes.
`timescale 1ns/1ps
module tb_cache_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int LT = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NP-1:0]    req_valid, req_ready, req_lock;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic [NP*MW-1:0] req_mask;
  logic             core_req_valid, core_req_ready;
  logic [AW-1:0]    core_req_addr;
  logic [DW-1:0]    core_req_data;
  logic [MW-1:0]    core_req_mask;
  logic             core_req_lock;
  logic [3:0]       core_req_port;
  logic             core_resp_valid, core_resp_ready, core_resp_success;
  logic [DW-1:0]    core_resp_data;
  logic [NP-1:0]    resp_valid, resp_ready;
  logic [DW-1:0]    resp_data;
  logic             resp_success, busy, locked, lock_timeout;
  logic [3:0]       lock_owner;

  always #5 clock = ~clock;

  cache_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_mask(req_mask), .req_lock(req_lock),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data),
    .core_req_mask(core_req_mask), .core_req_lock(core_req_lock),
    .core_req_port(core_req_port),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_data(core_resp_data), .core_resp_success(core_resp_success),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_success(resp_success),
    .busy(busy), .locked(locked), .lock_owner(lock_owner), .lock_timeout(lock_timeout)
  );

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          lock;
  } core_item_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          success;
  } resp_item_t;

  core_item_t exp_core[$];
  resp_item_t exp_resp[$];
  int total = 0;
  int bad   = 0;

  // Requester-side pending requests
  logic          pend_v    [NP];
  logic [AW-1:0] pend_addr [NP];
  logic [DW-1:0] pend_data [NP];
  logic [MW-1:0] pend_mask [NP];
  logic          pend_lock [NP];
  logic          gen_en;

  // Transaction-level arbiter model
  logic m_busy, m_locked, m_pulse_next;
  int   m_last, m_owner, m_cnt;
  int   cur_port;
  logic cur_lock, cur_success;

  // CacheCore model
  logic          c_owe;
  int            c_delay;
  logic [AW-1:0] c_addr;

  function automatic logic [DW-1:0] respWord(input logic [AW-1:0] a);
    return {8'hC3, a, 8'h3C, ~a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 1'b0; m_locked = 1'b0; m_pulse_next = 1'b0;
    m_last = NP - 1; m_owner = 0; m_cnt = 0;
    cur_port = 0; cur_lock = 1'b0; cur_success = 1'b0;
    c_owe = 1'b0; c_delay = 0; c_addr = '0;
    for (int p = 0; p < NP; p++) pend_v[p] = 1'b0;
    exp_core.delete();
    exp_resp.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_core_req_valid"}, core_req_valid, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_core_resp_ready"}, core_resp_ready, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_lock_owner"}, lock_owner, 0);
    checkOutput({tag, "_lock_timeout"}, lock_timeout, 0);
    checkOutput({tag, "_core_req_port"}, core_req_port, 0);
    checkOutput({tag, "_core_req_addr"}, core_req_addr, 0);
    checkOutput({tag, "_core_req_data"}, core_req_data, 0);
    checkOutput({tag, "_core_req_mask"}, core_req_mask, 0);
    checkOutput({tag, "_core_req_lock"}, core_req_lock, 0);
  endtask

  task automatic driveStress();
    req_valid = '1; req_lock = '1; req_addr = '1; req_data = '1; req_mask = '1;
    core_req_ready = 1'b1; core_resp_valid = 1'b1; core_resp_data = '1;
    core_resp_success = 1'b1; resp_ready = '1;
  endtask

  task automatic driveIdle();
    req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0; req_mask = '0;
    core_req_ready = 1'b0; core_resp_valid = 1'b0; core_resp_data = '0;
    core_resp_success = 1'b0; resp_ready = '0;
  endtask

  // One cycle per iteration: drive at negedge, then check and advance the model 1ns later.
  task automatic applyStimulus(input int cycles);
    int            winner, idx;
    logic [NP-1:0] exp_ready, exp_rv;
    core_item_t    ci;
    resp_item_t    ri;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      for (int p = 0; p < NP; p++) begin
        if (gen_en && !pend_v[p] && $urandom_range(0, 3) == 0) begin
          pend_v[p]    = 1'b1;
          pend_addr[p] = AW'($urandom);
          pend_data[p] = {$urandom, $urandom};
          pend_mask[p] = ($urandom_range(0, 2) == 0) ? '0 : MW'($urandom);
          pend_lock[p] = ($urandom_range(0, 5) == 0);
        end
        req_valid[p]          = pend_v[p];
        req_addr[p*AW +: AW]  = pend_addr[p];
        req_data[p*DW +: DW]  = pend_data[p];
        req_mask[p*MW +: MW]  = pend_mask[p];
        req_lock[p]           = pend_lock[p];
      end
      core_req_ready = ($urandom_range(0, 2) != 0);
      if (c_owe) begin
        if (c_delay > 0) begin
          c_delay--;
          core_resp_valid = 1'b0;
        end else begin
          core_resp_valid = 1'b1;
        end
        core_resp_data    = respWord(c_addr);
        core_resp_success = cur_success;
      end else begin
        core_resp_valid   = ($urandom_range(0, 4) == 0);
        core_resp_data    = {$urandom, $urandom};
        core_resp_success = 1'($urandom);
      end
      resp_ready = NP'($urandom);
      #1;
      checkOutput("busy", busy, m_busy);
      checkOutput("locked", locked, m_locked);
      checkOutput("lock_owner", lock_owner, m_owner);
      checkOutput("lock_timeout", lock_timeout, m_pulse_next);
      checkOutput("core_req_valid", core_req_valid, m_busy && !c_owe);
      exp_rv = '0;
      if (c_owe && core_resp_valid) exp_rv[cur_port] = 1'b1;
      checkOutput("resp_valid", resp_valid, exp_rv);
      checkOutput("core_resp_ready", core_resp_ready, c_owe ? resp_ready[cur_port] : 1'b0);
      m_pulse_next = 1'b0;
      if (!m_busy) begin
        winner = -1;
        for (int k = 1; k <= NP; k++) begin
          idx = (m_last + k) % NP;
          if (winner < 0 && pend_v[idx] && (!m_locked || idx == m_owner)) winner = idx;
        end
        exp_ready = '0;
        if (winner >= 0) exp_ready[winner] = 1'b1;
        checkOutput("req_ready", req_ready, exp_ready);
        if (m_locked && !pend_v[m_owner]) begin
          m_cnt++;
          if (m_cnt == LT) begin
            m_locked = 1'b0; m_cnt = 0; m_pulse_next = 1'b1;
          end
        end else begin
          m_cnt = 0;
        end
        if (winner >= 0) begin
          ci.port = winner; ci.addr = pend_addr[winner]; ci.data = pend_data[winner];
          ci.mask = pend_mask[winner]; ci.lock = pend_lock[winner];
          exp_core.push_back(ci);
          cur_success = 1'($urandom);
          ri.port = winner; ri.data = respWord(pend_addr[winner]); ri.success = cur_success;
          exp_resp.push_back(ri);
          cur_port = winner; cur_lock = pend_lock[winner];
          m_last = winner; m_busy = 1'b1; pend_v[winner] = 1'b0;
        end
      end else begin
        m_cnt = 0;
        checkOutput("req_ready_busy", req_ready, 0);
        if (core_req_valid && core_req_ready) begin
          c_owe = 1'b1; c_addr = core_req_addr; c_delay = $urandom_range(0, 3);
        end else if (c_owe && core_resp_valid && core_resp_ready) begin
          c_owe = 1'b0; m_busy = 1'b0;
          if (cur_lock && cur_success) begin
            m_locked = 1'b1; m_owner = cur_port;
          end else if (m_locked && cur_port == m_owner && !cur_lock) begin
            m_locked = 1'b0;
          end
        end
      end
    end
  endtask

  // Monitor: compares every core-side request and per-port response handshake.
  initial begin
    core_item_t    ci;
    resp_item_t    ri;
    logic [NP-1:0] oh;
    forever begin
      @(negedge clock);
      #2;
      if (reset && core_req_valid && core_req_ready) begin
        if (exp_core.size() == 0) begin
          checkOutput("core_req_unexpected", 1, 0);
        end else begin
          ci = exp_core.pop_front();
          checkOutput("core_req_port", core_req_port, ci.port);
          checkOutput("core_req_addr", core_req_addr, ci.addr);
          checkOutput("core_req_data", core_req_data, ci.data);
          checkOutput("core_req_mask", core_req_mask, ci.mask);
          checkOutput("core_req_lock", core_req_lock, ci.lock);
        end
      end
      if (reset && (resp_valid & resp_ready) != '0) begin
        if (exp_resp.size() == 0) begin
          checkOutput("resp_unexpected", 1, 0);
        end else begin
          ri = exp_resp.pop_front();
          oh = '0;
          oh[ri.port] = 1'b1;
          checkOutput("resp_port", resp_valid, oh);
          checkOutput("resp_data", resp_data, ri.data);
          checkOutput("resp_success", resp_success, ri.success);
        end
      end
    end
  end

  initial begin
    gen_en = 1'b0;
    modelReset();
    driveStress();
    repeat (2) @(negedge clock);
    #1;
    checkResetOutputs("reset");
    @(negedge clock);
    driveIdle();
    reset = 1'b1;

    gen_en = 1'b1;
    applyStimulus(2500);

    for (int i = 0; i < 300 && !c_owe; i++) applyStimulus(1);
    checkOutput("reach_wait_resp", c_owe, 1);
    @(negedge clock);
    reset = 1'b0;
    driveStress();
    #1;
    checkResetOutputs("mid_reset");
    modelReset();
    @(negedge clock);
    driveIdle();
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(1500);

    gen_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!m_busy && !pend_v[0] && !pend_v[1] && !pend_v[2] && !pend_v[3]) break;
      applyStimulus(1);
    end
    applyStimulus(2);
    checkOutput("drain_idle", m_busy, 0);
    checkOutput("core_queue_left", exp_core.size(), 0);
    checkOutput("resp_queue_left", exp_resp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters sharing one CacheCore (legal range 2..16).
REQ-002 SHALL have parameter ADDR_W, default 24, request address width.
REQ-003 SHALL have parameter DATA_W, default 512, data width; MASK_W = DATA_W/8.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 255, idle cycles before a held lock is forcibly released.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
REQ-007 req_valid / req_ready  in / out  NUM_PORTS  per-port request handshake.
REQ-008 req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 req_data, req_mask, req_lock  in  NUM_PORTS*DATA_W, NUM_PORTS*MASK_W, NUM_PORTS  per-port payload; mask 0 = read.
REQ-010 core_req_valid / core_req_ready  out / in  1  request handshake to CacheCore.
REQ-011 core_req_addr, core_req_data, core_req_mask, core_req_lock, core_req_port  out  ADDR_W, DATA_W, MASK_W, 1, 4  registered payload; port = granted index.
REQ-012 core_resp_valid / core_resp_ready  in / out  1  CacheCore response handshake.
REQ-013 core_resp_data, core_resp_success  in  DATA_W, 1  CacheCore response payload.
REQ-014 resp_valid / resp_ready  out / in  NUM_PORTS  per-port response handshake.
REQ-015 resp_data, resp_success  out  DATA_W, 1  shared combinational copy of core_resp_data / core_resp_success.
REQ-016 busy, locked, lock_owner, lock_timeout  out  1, 1, 4, 1  status; lock_timeout is a one-cycle pulse.

Function
REQ-017 States: IDLE, ISSUE, WAIT_RESP; exactly one transaction is outstanding at a time.
REQ-018 IDLE: eligible set = req_valid, restricted to lock_owner alone while locked=1.
REQ-019 Grant: round-robin, searching from last_grant+1 upward with wrap at NUM_PORTS-1 -> 0.
REQ-020 In IDLE, req_ready is 1 only for the winning port, combinationally; other ports and all other states: 0.
REQ-021 On the accept handshake: payload and port index are latched, last_grant is updated, next state ISSUE.
REQ-022 ISSUE: core_req_valid=1 starting the cycle after accept (latency 1); payload holds stable until core_req_ready; then WAIT_RESP.
REQ-023 WAIT_RESP: resp_valid[g] = core_resp_valid for granted port g only; core_resp_ready = resp_ready[g].
REQ-024 On the response handshake the next state is IDLE; a new accept is possible the following cycle.
REQ-025 Lock acquire: a response handshake with latched lock=1 and core_resp_success=1 sets locked=1 and lock_owner=g.
REQ-026 Lock release: a response handshake for the owner with latched lock=0 clears locked; lock_owner holds its value.
REQ-027 A failed locked request (success=0) leaves lock state unchanged.
REQ-028 Timeout counter: increments each IDLE cycle while locked=1 and req_valid[lock_owner]=0; clears otherwise.
REQ-029 When the timeout counter reaches LOCK_TIMEOUT: locked cleared, lock_timeout pulses one cycle, counter cleared.
REQ-030 Timeout and an owner accept in the same cycle: accept wins, no release.
REQ-031 Non-owner requests while locked stay pending (ready=0); none are dropped.
REQ-032 busy = 1 in ISSUE and WAIT_RESP.
REQ-033 Output drive: unselected resp_valid bits are 0; core_resp_valid seen in IDLE/ISSUE is ignored (core_resp_ready=0).

Reset
REQ-034 reset=0 forces IDLE immediately, asynchronously, including mid-transaction; the in-flight transaction is abandoned.
REQ-035 Reset values: all valid/ready outputs 0, payload registers 0, locked 0, lock_owner 0, lock_timeout 0, counter 0.
REQ-036 Reset value of last_grant is NUM_PORTS-1, so port 0 has first priority after reset.

Verification
REQ-037 Ports 0..3 all valid from reset, core ready, one-cycle responses -> grants in order 0,1,2,3,0; core_req_port matches each grant.
REQ-038 Port 2 read to 0x40, core_req_ready delayed 5 cycles -> core_req_addr=0x40 held stable; resp_valid[2] only; response data 0x3 delivered.
REQ-039 Port 1 lock=1 and success=1, then ports 0 and 1 valid -> only port 1 granted until it completes a lock=0 request; then port 0 is granted.
REQ-040 Lock held by port 3, port 3 idle, LOCK_TIMEOUT=8 -> lock_timeout pulses after 8 IDLE cycles; port 0 granted next cycle.
REQ-041 Port 0 lock=1, response success=0 -> locked stays 0.
REQ-042 reset asserted in WAIT_RESP -> all outputs 0 that cycle; after release, a fresh request from port 0 completes normally.
